branch_predictor: RTL and testbench

- Fetch-side branch predictor: a branch history table (BHT) of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB).
- Gives fetch a taken/target guess for the current PC.
- Trained at execute by the resolved outcome from the branch decision logic. Raises a registered mispredict/redirect to flush the pipeline.
- Sits between fetch PC generation and the execute-stage branch resolution.

---
 rtl/branch_predictor.sv | 155 +++++++++++++++
 tb/tb_branch_predictor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side predictor built from a table of 2-bit
// saturating counters (BHT) and a direct-mapped branch target buffer (BTB).
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   fetch_pc          PC being fetched; indexes both tables
//   pred_taken        combinational taken guess for fetch_pc
//   pred_target       BTB target for fetch_pc (meaningful when pred_taken=1)
//   res_*             execute-stage resolution of one instruction per cycle
//   mispredict        registered one-cycle flush pulse
//   redirect_pc       correct fetch PC accompanying mispredict
//   init_busy         high while the post-reset table sweep is running
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = XLEN - IDX_BITS - 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic            res_is_branch,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            init_busy
);

  localparam int ENTRIES = 2 ** IDX_BITS;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  logic                init_busy_q, init_busy_d;
  logic                mispredict_q, mispredict_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;

  // Table storage: never reset directly, the INIT sweep rewrites every entry.
  logic [1:0]          cnt_q        [ENTRIES];
  logic                btb_valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
  logic [XLEN-1:0]     btb_target_q [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx, res_idx, tbl_idx;
  logic [TAG_BITS-1:0] fetch_tag, res_tag;
  logic [1:0]          cur_cnt, cnt_wdata;
  logic                cnt_we, btb_we, btb_wvalid, eff_taken;
  logic                unused_fetch_lsbs;

  assign fetch_idx         = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag         = fetch_pc[XLEN-1:IDX_BITS+2];
  assign res_idx           = res_pc[IDX_BITS+1:2];
  assign res_tag           = res_pc[XLEN-1:IDX_BITS+2];
  assign unused_fetch_lsbs = ^fetch_pc[1:0];

  // Lookup reads the stored state only, so a same-cycle update to the same
  // index is seen from the following cycle.
  always_comb begin
    pred_taken  = (state_q == S_RUN) && btb_valid_q[fetch_idx] &&
                  (btb_tag_q[fetch_idx] == fetch_tag) && cnt_q[fetch_idx][1];
    pred_target = btb_target_q[fetch_idx];
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    init_busy_d   = init_busy_q;
    mispredict_d  = 1'b0;
    redirect_pc_d = redirect_pc_q;
    tbl_idx       = res_idx;
    cnt_we        = 1'b0;
    cnt_wdata     = 2'b01;
    btb_we        = 1'b0;
    btb_wvalid    = 1'b0;
    cur_cnt       = cnt_q[res_idx];
    // A non-branch that was predicted taken is a BTB alias: treat as not taken.
    eff_taken     = res_is_branch & res_taken;

    case (state_q)
      S_INIT: begin
        tbl_idx   = ptr_q;
        cnt_we    = 1'b1;
        cnt_wdata = 2'b01;
        btb_we    = 1'b1;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d     = S_RUN;
          init_busy_d = 1'b0;
        end
      end
      S_RUN: begin
        if (res_valid) begin
          if ((eff_taken != res_pred_taken) ||
              (eff_taken && res_pred_taken && (res_target != res_pred_target))) begin
            mispredict_d  = 1'b1;
            redirect_pc_d = eff_taken ? res_target
                                      : res_pc + {{(XLEN-3){1'b0}}, 3'b100};
          end
          if (res_is_branch) begin
            cnt_we = 1'b1;
            if (res_taken) begin
              cnt_wdata  = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'b01;
              btb_we     = 1'b1;
              btb_wvalid = 1'b1;
            end else begin
              cnt_wdata  = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'b01;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      ptr_q         <= '0;
      init_busy_q   <= 1'b1;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      init_busy_q   <= init_busy_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && cnt_we) begin
      cnt_q[tbl_idx] <= cnt_wdata;
    end
    if (rst_n && btb_we) begin
      btb_valid_q[tbl_idx]  <= btb_wvalid;
      btb_tag_q[tbl_idx]    <= btb_wvalid ? res_tag : '0;
      btb_target_q[tbl_idx] <= btb_wvalid ? res_target : '0;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign init_busy   = init_busy_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid, res_is_branch, res_taken, res_pred_taken;
  logic [31:0] res_pc, res_target, res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        init_busy;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .IDX_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .init_busy(init_busy)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  // Reference model: per-index counter value, BTB contents, and the
  // expected registered outputs.
  int          m_cnt [64];
  bit          m_vld [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_tgt [64];
  bit          m_known = 1'b0;
  bit          m_init = 1'b1;
  int          m_init_n = 0;
  bit          m_misp = 1'b0;
  logic [31:0] m_redir = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_pred(input logic [31:0] pc);
    int i;
    i = int'(pc[7:2]);
    return !m_init && m_vld[i] && (m_tag[i] == pc[31:8]) && (m_cnt[i] >= 2);
  endfunction

  task automatic model_update();
    bit eff;
    int i;
    if (!rst_n) begin
      m_known = 1'b1;
      m_init = 1'b1;
      m_init_n = 0;
      m_misp = 1'b0;
      m_redir = '0;
    end else begin
      m_misp = 1'b0;
      if (m_init) begin
        m_init_n++;
        if (m_init_n == 64) begin
          m_init = 1'b0;
          for (int k = 0; k < 64; k++) begin
            m_cnt[k] = 1;
            m_vld[k] = 1'b0;
          end
        end
      end else if (res_valid) begin
        eff = res_is_branch && res_taken;
        if ((eff != res_pred_taken) ||
            (eff && res_pred_taken && (res_target != res_pred_target))) begin
          m_misp = 1'b1;
          m_redir = eff ? res_target : res_pc + 32'd4;
        end
        if (res_is_branch) begin
          i = int'(res_pc[7:2]);
          if (res_taken) begin
            if (m_cnt[i] < 3) m_cnt[i]++;
            m_vld[i] = 1'b1;
            m_tag[i] = res_pc[31:8];
            m_tgt[i] = res_target;
          end else if (m_cnt[i] > 0) begin
            m_cnt[i]--;
          end
        end
      end
    end
  endtask

  // One clock: check all outputs mid-cycle against the model, then advance
  // the model on the rising edge with the inputs the DUT sampled.
  task automatic tick();
    bit ep;
    @(negedge clk);
    if (m_known) begin
      ep = m_pred(fetch_pc);
      chk("init_busy", {31'b0, init_busy}, {31'b0, m_init});
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, ep});
      if (ep) chk("pred_target", pred_target, m_tgt[fetch_pc[7:2]]);
      chk("mispredict", {31'b0, mispredict}, {31'b0, m_misp});
      chk("redirect_pc", redirect_pc, m_redir);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] pc, input bit exp_t,
                      input logic [31:0] exp_tgt);
    fetch_pc = pc;
    #1;
    chk(tag, {31'b0, pred_taken}, {31'b0, exp_t});
    if (exp_t) chk({tag, "_tgt"}, pred_target, exp_tgt);
  endtask

  task automatic resolve(input logic [31:0] pc, input bit br, input bit tk,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    res_valid = 1'b1;
    res_is_branch = br;
    res_pc = pc;
    res_taken = tk;
    res_target = tgt;
    res_pred_taken = ptk;
    res_pred_target = ptgt;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic chk_misp(input string tag, input bit exp_m, input logic [31:0] exp_r);
    chk({tag, "_misp"}, {31'b0, mispredict}, {31'b0, exp_m});
    chk({tag, "_redir"}, redirect_pc, exp_r);
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] p;
    p = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
    if ($urandom_range(0, 9) == 0) p = $urandom;
    return p;
  endfunction

  initial begin
    int n;
    rst_n = 1'b0;
    fetch_pc = '0;
    res_valid = 1'b0;
    res_is_branch = 1'b0;
    res_pc = '0;
    res_taken = 1'b0;
    res_target = '0;
    res_pred_taken = 1'b0;
    res_pred_target = '0;

    // Reset for two cycles, then count the INIT sweep while a mismatching
    // resolve is presented every cycle.
    tick();
    tick();
    chk_misp("reset", 1'b0, 32'h0);
    chk("reset_busy", {31'b0, init_busy}, 32'd1);
    rst_n = 1'b1;
    res_valid = 1'b1; res_is_branch = 1'b1; res_pc = 32'h100;
    res_taken = 1'b1; res_target = 32'h80; res_pred_taken = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("init_len", n, 32'd64);
    res_valid = 1'b0;
    tick();
    chk_misp("init_ignored", 1'b0, 32'h0);

    // Cold miss then train.
    peek("cold_miss", 32'h100, 1'b0, 32'h0);
    resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    chk_misp("cold", 1'b1, 32'h80);
    peek("trained", 32'h100, 1'b1, 32'h80);
    peek("alias_0x200", 32'h200, 1'b0, 32'h0);

    // Same-cycle lookup and update of index 0: old counter value is seen.
    peek("collide_old", 32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
    chk_misp("collide", 1'b1, 32'h104);
    peek("collide_new", 32'h100, 1'b0, 32'h0);

    // Saturation and hysteresis at 0x200.
    repeat (3) resolve(32'h200, 1'b1, 1'b1, 32'h240, 1'b0, 32'h0);
    peek("sat_taken", 32'h200, 1'b1, 32'h240);
    resolve(32'h200, 1'b1, 1'b0, 32'h0, 1'b1, 32'h240);
    peek("hyst_1nt", 32'h200, 1'b1, 32'h240);
    resolve(32'h200, 1'b1, 1'b0, 32'h0, 1'b1, 32'h240);
    peek("hyst_2nt", 32'h200, 1'b0, 32'h0);
    repeat (5) resolve(32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve(32'h200, 1'b1, 1'b1, 32'h240, 1'b0, 32'h0);
    peek("sat_floor", 32'h200, 1'b0, 32'h0);

    // Not-taken mispredict with PC+4 wrap.
    resolve(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234);
    chk_misp("wrap", 1'b1, 32'h0);

    // Target mismatch, both taken.
    resolve(32'h344, 1'b1, 1'b1, 32'h400, 1'b1, 32'h300);
    chk_misp("tgt_mismatch", 1'b1, 32'h400);
    peek("tgt_updated", 32'h344, 1'b1, 32'h400);

    // Non-branch predicted taken (BTB alias).
    resolve(32'h500, 1'b0, 1'b1, 32'h600, 1'b1, 32'h600);
    chk_misp("nonbranch", 1'b1, 32'h504);

    // Correct prediction: no pulse, redirect holds.
    resolve(32'h344, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400);
    chk_misp("correct", 1'b0, 32'h504);

    // Mid-RUN reset with an offending resolve on the same edge.
    rst_n = 1'b0;
    resolve(32'h344, 1'b1, 1'b0, 32'h0, 1'b1, 32'h400);
    rst_n = 1'b1;
    chk_misp("midrun_rst", 1'b0, 32'h0);
    chk("midrun_busy", {31'b0, init_busy}, 32'd1);
    peek("midrun_init_pred", 32'h344, 1'b0, 32'h0);
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("reinit_len", n, 32'd64);
    peek("cleared_344", 32'h344, 1'b0, 32'h0);
    peek("cleared_100", 32'h100, 1'b0, 32'h0);

    // Randomized traffic against the model, with rare resets.
    for (int it = 0; it < 1500; it++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      fetch_pc = pick_pc();
      res_valid = ($urandom_range(0, 3) != 0);
      res_is_branch = ($urandom_range(0, 7) != 0);
      res_pc = pick_pc();
      res_taken = $urandom_range(0, 1) == 1;
      res_target = ($urandom_range(0, 1) == 1) ? 32'h800 : pick_pc();
      if ($urandom_range(0, 1) == 1) begin
        res_pred_taken = m_pred(res_pc);
        res_pred_target = m_tgt[res_pc[7:2]];
      end else begin
        res_pred_taken = $urandom_range(0, 1) == 1;
        res_pred_target = ($urandom_range(0, 1) == 1) ? 32'h800 : pick_pc();
      end
      tick();
    end
    rst_n = 1'b1;
    res_valid = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
